// File: rtl/systolic_array_controller_if.sv
// Job/buffer-control bundle between scheduler, systolic_array_controller and the array buffers.
// master = scheduler/bench side, slave = controller side.
interface systolic_array_controller_if #(
  parameter int COLS      = 4,
  parameter int VEC_CNT_W = 16
);
  localparam int WA_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic                 start;
  logic                 abort;
  logic [VEC_CNT_W-1:0] num_vectors;
  logic                 stall;
  logic                 array_en;
  logic                 array_sync_rst;
  logic                 array_load;
  logic                 weight_rd_en;
  logic [WA_W-1:0]      weight_rd_addr;
  logic                 input_rd_en;
  logic [VEC_CNT_W-1:0] input_rd_addr;
  logic                 psum_valid;
  logic [VEC_CNT_W-1:0] psum_wr_addr;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, num_vectors, stall,
    input  array_en, array_sync_rst, array_load, weight_rd_en, weight_rd_addr,
           input_rd_en, input_rd_addr, psum_valid, psum_wr_addr, busy, done
  );

  modport slave (
    input  start, abort, num_vectors, stall,
    output array_en, array_sync_rst, array_load, weight_rd_en, weight_rd_addr,
           input_rd_en, input_rd_addr, psum_valid, psum_wr_addr, busy, done
  );
endinterface

// File: rtl/systolic_array_controller.sv
// Weight-stationary tile sequencer: CLEAR -> LOAD (COLS weights) -> COMPUTE (N+ROWS+COLS-1) -> FIN.
// Outputs decode from registered state; STALL freezes LOAD/COMPUTE. CTRL_PERF_CNT_EN adds perf counters.
module systolic_array_controller #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int VEC_CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  systolic_array_controller_if.slave bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] active_cycles,
  output logic [31:0] stall_cycles
`endif
);

  localparam int WA_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CW   = VEC_CNT_W + 1;
  localparam int LAT  = ROWS + COLS - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [VEC_CNT_W-1:0] n_q, n_d;
  logic [CW-1:0]        comp_last;

  // One extra bit keeps N+LAT-1 from wrapping at the maximum job size.
  assign comp_last = {1'b0, n_q} + CW'(LAT) - CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d     = bus.num_vectors;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!bus.stall) begin
          if (cnt_q == CW'(COLS - 1)) begin
            cnt_d   = '0;
            state_d = (n_q == '0) ? S_FIN : S_COMPUTE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (!bus.stall) begin
          if (cnt_q == comp_last) begin
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (bus.abort && (state_q != S_IDLE)) begin
      cnt_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  // Addresses track the held counter during a stall; only strobes are gated.
  always_comb begin
    bus.array_en       = 1'b0;
    bus.array_sync_rst = 1'b0;
    bus.array_load     = 1'b0;
    bus.weight_rd_en   = 1'b0;
    bus.weight_rd_addr = '0;
    bus.input_rd_en    = 1'b0;
    bus.input_rd_addr  = '0;
    bus.psum_valid     = 1'b0;
    bus.psum_wr_addr   = '0;
    bus.busy           = (state_q != S_IDLE);
    bus.done           = (state_q == S_FIN);
    case (state_q)
      S_CLEAR: begin
        bus.array_en       = 1'b1;
        bus.array_sync_rst = 1'b1;
      end
      S_LOAD: begin
        bus.array_en       = !bus.stall;
        bus.array_load     = 1'b1;
        bus.weight_rd_en   = !bus.stall;
        bus.weight_rd_addr = WA_W'(CW'(COLS - 1) - cnt_q);
      end
      S_COMPUTE: begin
        bus.array_en      = !bus.stall;
        bus.input_rd_en   = !bus.stall && (cnt_q < {1'b0, n_q});
        bus.input_rd_addr = VEC_CNT_W'(cnt_q);
        if (cnt_q >= CW'(LAT)) begin
          bus.psum_valid   = !bus.stall;
          bus.psum_wr_addr = VEC_CNT_W'(cnt_q - CW'(LAT));
        end
      end
      default: ;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] act_q, act_d;
  logic [31:0] stl_q, stl_d;

  always_comb begin
    act_d = act_q;
    stl_d = stl_q;
    if ((state_q == S_IDLE) && bus.start) begin
      act_d = '0;
      stl_d = '0;
    end else begin
      if ((state_q != S_IDLE) && (act_q != '1)) begin
        act_d = act_q + 32'd1;
      end
      if (((state_q == S_LOAD) || (state_q == S_COMPUTE)) && bus.stall && (stl_q != '1)) begin
        stl_d = stl_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      stl_q <= '0;
    end else begin
      act_q <= act_d;
      stl_q <= stl_d;
    end
  end

  assign active_cycles = act_q;
  assign stall_cycles  = stl_q;
`endif

endmodule
